// File: rtl/bsg_manycore_host_req_arbiter_if.sv
// Request-side and loader-link-side signals of the host request arbiter.
// The slave modport is the arbiter's view; the master modport is the host/link side.
interface bsg_manycore_host_req_arbiter_if #(
  parameter int num_req_p         = 2,
  parameter int packet_width_p    = 32,
  parameter int max_out_credits_p = 16
);
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);

  logic [num_req_p-1:0]                req_v_i;
  logic [num_req_p*packet_width_p-1:0] req_packet_i;
  logic [num_req_p-1:0]                req_yumi_o;
  logic                                out_v_o;
  logic [packet_width_p-1:0]           out_packet_o;
  logic                                out_ready_i;
  logic                                returned_credit_v_i;
  logic [credit_width_lp-1:0]          credits_o;
  logic                                fence_v_i;
  logic                                fence_done_o;

  modport slave (
    input  req_v_i, req_packet_i, out_ready_i, returned_credit_v_i, fence_v_i,
    output req_yumi_o, out_v_o, out_packet_o, credits_o, fence_done_o
  );

  modport master (
    output req_v_i, req_packet_i, out_ready_i, returned_credit_v_i, fence_v_i,
    input  req_yumi_o, out_v_o, out_packet_o, credits_o, fence_done_o
  );
endinterface

// File: rtl/bsg_manycore_host_req_arbiter.sv
// Round-robin arbiter sharing the host loader link among several request sources,
// with an outstanding-packet credit limit and a drain fence.
module bsg_manycore_host_req_arbiter #(
  parameter int num_req_p         = 2,
  parameter int packet_width_p    = 32,
  parameter int max_out_credits_p = 16
) (
  input logic clk_i,
  input logic reset_i,
  bsg_manycore_host_req_arbiter_if.slave bus
);
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1);
  localparam int ptr_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
  localparam logic [ptr_width_lp-1:0]    rr_reset_lp    = ptr_width_lp'(num_req_p - 1);

  typedef enum logic {IDLE = 1'b0, FENCE = 1'b1} state_e;

  state_e                     state_q;
  logic                       out_v_q;
  logic [packet_width_p-1:0]  out_packet_q;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic [ptr_width_lp-1:0]    rr_q;

  logic                    slot_free;
  logic                    grant_found;
  logic [ptr_width_lp-1:0] grant_idx;
  logic                    can_grant;
  logic                    ret_ok;
  logic                    credits_full_now;
  logic                    fence_done;

  assign slot_free = ~out_v_q | bus.out_ready_i;

  generate
    if (num_req_p == 1) begin : g_single
      assign grant_found = bus.req_v_i[0];
      assign grant_idx   = '0;
    end else begin : g_rr
      // Scan starts one past the last winner so every source gets a turn.
      always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int off = 1; off <= num_req_p; off++) begin
          idx = (int'(rr_q) + off) % num_req_p;
          if (!grant_found && bus.req_v_i[idx]) begin
            grant_found = 1'b1;
            grant_idx   = ptr_width_lp'(idx);
          end
        end
      end
    end
  endgenerate

  assign can_grant = ~reset_i & (state_q == IDLE) & ~bus.fence_v_i & slot_free
                   & (credits_q != '0) & grant_found;

  // A return at full credit with no grant is dropped so the counter saturates.
  assign ret_ok = bus.returned_credit_v_i & ((credits_q != max_credits_lp) | can_grant);

  always_comb begin
    credits_d = credits_q;
    case ({can_grant, ret_ok})
      2'b10:   credits_d = credits_q - credit_width_lp'(1);
      2'b01:   credits_d = credits_q + credit_width_lp'(1);
      default: credits_d = credits_q;
    endcase
  end

  assign credits_full_now = (credits_q == max_credits_lp)
                          | (bus.returned_credit_v_i & (credits_q == max_credits_lp - credit_width_lp'(1)));
  assign fence_done = ~reset_i & (state_q == FENCE) & ~out_v_q & credits_full_now;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      out_v_q      <= 1'b0;
      out_packet_q <= '0;
      credits_q    <= max_credits_lp;
      rr_q         <= rr_reset_lp;
    end else begin
      out_v_q   <= can_grant | (out_v_q & ~bus.out_ready_i);
      credits_q <= credits_d;
      if (can_grant) begin
        out_packet_q <= bus.req_packet_i[grant_idx*packet_width_p +: packet_width_p];
        rr_q         <= grant_idx;
      end
      case (state_q)
        IDLE:    if (bus.fence_v_i) state_q <= FENCE;
        FENCE:   if (fence_done)    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(bus.returned_credit_v_i && (credits_q == max_credits_lp) && !can_grant))
        else $error("credit returned while all credits are available");
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_yumi
      assign bus.req_yumi_o[gi] = can_grant & (grant_idx == ptr_width_lp'(gi));
    end
  endgenerate

  assign bus.out_v_o      = out_v_q;
  assign bus.out_packet_o = out_packet_q;
  assign bus.credits_o    = credits_q;
  assign bus.fence_done_o = fence_done;
endmodule

// File: tb/tb_bsg_manycore_host_req_arbiter.sv
// Randomized bench for the host request arbiter: a cycle-level reference model
// predicts grants, credits and fence pulses; a scoreboard checks delivered packets.
module tb_bsg_manycore_host_req_arbiter;
  localparam int N   = 3;
  localparam int W   = 16;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bsg_manycore_host_req_arbiter_if #(.num_req_p(N), .packet_width_p(W), .max_out_credits_p(MAX)) bus ();

  bsg_manycore_host_req_arbiter #(.num_req_p(N), .packet_width_p(W), .max_out_credits_p(MAX)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  bit           src_v   [N];
  logic [W-1:0] src_pkt [N];

  int           m_credits, m_last, m_unret;
  bit           m_fence, m_out_v;
  logic [W-1:0] m_out_pkt;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_credits = MAX;
    m_last    = N - 1;
    m_unret   = 0;
    m_fence   = 0;
    m_out_v   = 0;
    m_out_pkt = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_v[i] = 0;
  endtask

  task automatic refill_all();
    for (int i = 0; i < N; i++)
      if (!src_v[i]) begin
        src_v[i]   = 1;
        src_pkt[i] = W'($urandom);
      end
  endtask

  // Called just after a rising edge; drives one cycle, checks it, advances the model.
  task automatic step(input bit rdy, input bit ret_req, input bit fen);
    bit           ret, grant, done, slot_free;
    int           g, best, d;
    logic [N-1:0] exp_yumi;
    ret = ret_req && (m_unret > 0);
    for (int i = 0; i < N; i++) begin
      bus.req_v_i[i]            = src_v[i];
      bus.req_packet_i[i*W +: W] = src_pkt[i];
    end
    bus.out_ready_i         = rdy;
    bus.returned_credit_v_i = ret;
    bus.fence_v_i           = fen;
    @(negedge clk);
    slot_free = !m_out_v || rdy;
    g    = -1;
    best = N;
    // Winner is the requester closest after the previous winner in circular order.
    for (int i = 0; i < N; i++)
      if (src_v[i]) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (d < best) begin best = d; g = i; end
      end
    grant    = !m_fence && !fen && slot_free && (m_credits > 0) && (g >= 0);
    exp_yumi = '0;
    if (grant) exp_yumi[g] = 1'b1;
    done = m_fence && !m_out_v && (m_credits + int'(ret) == MAX);
    check("yumi",       longint'(bus.req_yumi_o),   longint'(exp_yumi));
    check("fence_done", longint'(bus.fence_done_o), longint'(done));
    check("credits",    longint'(bus.credits_o),    longint'(m_credits));
    check("out_v",      longint'(bus.out_v_o),      longint'(m_out_v));
    if (m_out_v) check("out_packet", longint'(bus.out_packet_o), longint'(m_out_pkt));
    if (m_out_v && rdy) m_unret++;
    if (ret) m_unret--;
    m_out_v = grant || (m_out_v && !rdy);
    if (grant) begin
      m_out_pkt = src_pkt[g];
      exp_q.push_back(src_pkt[g]);
      src_v[g] = 0;
      m_last   = g;
    end
    m_credits = m_credits + int'(ret) - int'(grant);
    m_fence   = m_fence ? !done : fen;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_i === 1'b0 && bus.out_v_o === 1'b1 && bus.out_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: got packet %0h expected none pending", bus.out_packet_o);
      end else begin
        check("sb_packet", longint'(bus.out_packet_o), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < N; i++) src_v[i] = 0;
    repeat (10) step(1, 1, 0);
  endtask

  initial begin
    reset_i                 = 1'b1;
    bus.req_v_i             = '0;
    bus.req_packet_i        = '0;
    bus.out_ready_i         = 1'b0;
    bus.returned_credit_v_i = 1'b0;
    bus.fence_v_i           = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_v",      longint'(bus.out_v_o),      0);
    check("rst_out_packet", longint'(bus.out_packet_o), 0);
    check("rst_yumi",       longint'(bus.req_yumi_o),   0);
    check("rst_fence_done", longint'(bus.fence_done_o), 0);
    check("rst_credits",    longint'(bus.credits_o),    MAX);
    reset_i = 1'b0;

    // Single source, then return its credit.
    src_v[0] = 1; src_pkt[0] = 16'h1234;
    step(1, 0, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);

    // All sources busy: round-robin until credits run out, then one return.
    for (int k = 0; k < 7; k++) begin refill_all(); step(1, 0, 0); end
    refill_all(); step(1, 1, 0);
    for (int k = 0; k < 3; k++) begin refill_all(); step(1, 0, 0); end
    drain();

    // Backpressure: output held for 5 cycles, then ready rises.
    refill_all(); step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    drain();

    // Fence with three outstanding, requests pending throughout.
    for (int k = 0; k < 3; k++) begin refill_all(); step(1, 0, 0); end
    step(1, 0, 1);
    for (int k = 0; k < 5; k++) begin refill_all(); step(1, 1, 0); end
    drain();

    // Fence with nothing outstanding.
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 0);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_v[i] && ($urandom % 2 == 0)) begin
          src_v[i]   = 1;
          src_pkt[i] = W'($urandom);
        end else if (src_v[i] && ($urandom % 16 == 0)) begin
          src_v[i] = 0;
        end
      end
      step($urandom % 4 != 0, $urandom % 3 == 0, $urandom % 40 == 0);
    end
    drain();

    // Reset while fencing with a packet stuck in the output register.
    src_v[1] = 1; src_pkt[1] = 16'hbeef;
    step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    reset_i                 = 1'b1;
    bus.req_v_i             = '1;
    bus.out_ready_i         = 1'b0;
    bus.returned_credit_v_i = 1'b0;
    bus.fence_v_i           = 1'b0;
    @(negedge clk);
    check("rst_mid_yumi",       longint'(bus.req_yumi_o),   0);
    check("rst_mid_fence_done", longint'(bus.fence_done_o), 0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
    check("rst_mid_out_v",   longint'(bus.out_v_o),   0);
    check("rst_mid_credits", longint'(bus.credits_o), MAX);
    src_v[2] = 1; src_pkt[2] = 16'h0f0f;
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
